// File: rtl/fewcore_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fewcore_pkg
// Description : Shared opcode constants, instruction field positions and the
//               decode/issue state encoding used by fetch, decode and execute.
// Revision    : 1.0 - initial release
// ============================================================================
package fewcore_pkg;

    // Opcodes that do not write rd; every other opcode writes rd.
    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_STORE  = 4'hA;
    localparam logic [3:0] OP_BRANCH = 4'hB;
    localparam logic [3:0] OP_HALT   = 4'hF;

    // Instruction field bit positions.
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } di_state_t;

    function automatic logic op_writes_rd(input logic [3:0] op);
        return !((op == OP_NOP) || (op == OP_STORE) ||
                 (op == OP_BRANCH) || (op == OP_HALT));
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Pending-write scoreboard for the architectural registers.
//               Lookups see the current writeback already retired (the
//               register file writes on negedge, ahead of the posedge read).
//               A same-cycle set and clear on one register keeps it pending,
//               since the set belongs to the newer producer.
// Ports       : clk, rst_n          clock / synchronous active-low reset
//               i_set, i_set_rd     mark a register pending (issue)
//               i_clr, i_clr_rd     retire a register (writeback)
//               i_rs1/i_rs2/i_rd    lookup addresses
//               o_busy_*            bypassed pending status of each lookup
//               o_wb_err            sticky: writeback to a non-pending reg
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int AMOUNT     = 16,
    parameter int ADDRESSLEN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_set,
    input  logic [ADDRESSLEN-1:0] i_set_rd,
    input  logic                  i_clr,
    input  logic [ADDRESSLEN-1:0] i_clr_rd,
    input  logic [ADDRESSLEN-1:0] i_rs1,
    input  logic [ADDRESSLEN-1:0] i_rs2,
    input  logic [ADDRESSLEN-1:0] i_rd,
    output logic                  o_busy_rs1,
    output logic                  o_busy_rs2,
    output logic                  o_busy_rd,
    output logic                  o_wb_err
);

    logic [AMOUNT-1:0] r_pending;
    logic [AMOUNT-1:0] w_set;
    logic [AMOUNT-1:0] w_clr;
    logic [AMOUNT-1:0] w_pend_byp;
    logic [AMOUNT-1:0] w_pending_nxt;
    logic              r_wb_err;

    genvar gi;
    generate
        for (gi = 0; gi < AMOUNT; gi++) begin : g_reg
            assign w_set[gi]         = i_set && (i_set_rd == ADDRESSLEN'(gi));
            assign w_clr[gi]         = i_clr && (i_clr_rd == ADDRESSLEN'(gi));
            assign w_pend_byp[gi]    = r_pending[gi] && !w_clr[gi];
            assign w_pending_nxt[gi] = w_set[gi] || w_pend_byp[gi];
        end
    endgenerate

    assign o_busy_rs1 = w_pend_byp[i_rs1];
    assign o_busy_rs2 = w_pend_byp[i_rs2];
    assign o_busy_rd  = w_pend_byp[i_rd];
    assign o_wb_err   = r_wb_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_wb_err  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (i_clr && !r_pending[i_clr_rd]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue
// Description : Decode/issue stage in front of the 16x32 register file. Holds
//               one instruction, drives the regfile read addresses, stalls on
//               RAW/WAW hazards and offers op/rd/imm to execute (valid/ready).
// Ports       : clk, rst_n                   clock / sync active-low reset
//               instrIn/instrValid/instrReady fetch handshake
//               RAddress1/RAddress2           regfile read addresses
//               issueValid/issueReady         execute handshake
//               issueOpcode/Rd/Imm/Writes     decoded fields of held instr
//               wbValid/wbRd                  writeback retiring a register
//               flush                         drop the held instruction
//               halted, wbErr, stallCycles    status
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue
    import fewcore_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int AMOUNT     = 16,
    parameter int ADDRESSLEN = 4,
    parameter int STALLW     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       instrIn,
    input  logic                  instrValid,
    output logic                  instrReady,
    output logic [ADDRESSLEN-1:0] RAddress1,
    output logic [ADDRESSLEN-1:0] RAddress2,
    output logic                  issueValid,
    input  logic                  issueReady,
    output logic [3:0]            issueOpcode,
    output logic [ADDRESSLEN-1:0] issueRd,
    output logic [XLEN-1:0]       issueImm,
    output logic                  issueWrites,
    input  logic                  wbValid,
    input  logic [ADDRESSLEN-1:0] wbRd,
    input  logic                  flush,
    output logic                  halted,
    output logic                  wbErr,
    output logic [STALLW-1:0]     stallCycles
);

    di_state_t         r_state;
    di_state_t         w_state_nxt;
    logic [XLEN-1:0]   r_instr;
    logic [STALLW-1:0] r_stall;
    logic              w_load;
    logic              w_fire;
    logic              w_set;
    logic              w_hazard;
    logic              w_is_halt;
    logic              w_busy_rs1;
    logic              w_busy_rs2;
    logic              w_busy_rd;

    // Decode of the held instruction.
    assign issueOpcode = r_instr[OP_MSB:OP_LSB];
    assign issueRd     = r_instr[RD_MSB:RD_LSB];
    assign RAddress1   = r_instr[RS1_MSB:RS1_LSB];
    assign RAddress2   = r_instr[RS2_MSB:RS2_LSB];
    assign issueImm    = {{(XLEN-16){r_instr[IMM_MSB]}}, r_instr[IMM_MSB:IMM_LSB]};
    assign issueWrites = op_writes_rd(issueOpcode);
    assign w_is_halt   = (issueOpcode == OP_HALT);

    assign w_hazard   = w_busy_rs1 || w_busy_rs2 || (w_busy_rd && issueWrites);
    assign issueValid = (r_state == ST_HOLD) && !w_hazard;
    assign w_fire     = issueValid && issueReady;
    // A flushed instruction never reaches the scoreboard.
    assign w_set      = w_fire && issueWrites && !flush;

    // A firing HALT takes no successor: the stage freezes behind it.
    assign instrReady = (r_state == ST_EMPTY) ||
                        ((r_state == ST_HOLD) && w_fire && !w_is_halt);
    assign halted      = (r_state == ST_HALTED);
    assign stallCycles = r_stall;

    reg_scoreboard #(
        .AMOUNT     (AMOUNT),
        .ADDRESSLEN (ADDRESSLEN)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set      (w_set),
        .i_set_rd   (issueRd),
        .i_clr      (wbValid),
        .i_clr_rd   (wbRd),
        .i_rs1      (RAddress1),
        .i_rs2      (RAddress2),
        .i_rd       (issueRd),
        .o_busy_rs1 (w_busy_rs1),
        .o_busy_rs2 (w_busy_rs2),
        .o_busy_rd  (w_busy_rd),
        .o_wb_err   (wbErr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (instrValid) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_fire) begin
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (instrValid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HALTED;
            end
        endcase
        // Flush overrides any issue or load this cycle; HALTED only leaves on reset.
        if (flush && (r_state != ST_HALTED)) begin
            w_state_nxt = ST_EMPTY;
            w_load      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_instr <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_instr <= instrIn;
            end
            if ((r_state == ST_HOLD) && w_hazard && (r_stall != {STALLW{1'b1}})) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue
// Description : Directed self-checking bench for decode_issue with a
//               behavioural model of the stage and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instrIn;
    logic        instrValid;
    logic        instrReady;
    logic [3:0]  RAddress1;
    logic [3:0]  RAddress2;
    logic        issueValid;
    logic        issueReady;
    logic [3:0]  issueOpcode;
    logic [3:0]  issueRd;
    logic [31:0] issueImm;
    logic        issueWrites;
    logic        wbValid;
    logic [3:0]  wbRd;
    logic        flush;
    logic        halted;
    logic        wbErr;
    logic [15:0] stallCycles;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instrIn     (instrIn),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .RAddress1   (RAddress1),
        .RAddress2   (RAddress2),
        .issueValid  (issueValid),
        .issueReady  (issueReady),
        .issueOpcode (issueOpcode),
        .issueRd     (issueRd),
        .issueImm    (issueImm),
        .issueWrites (issueWrites),
        .wbValid     (wbValid),
        .wbRd        (wbRd),
        .flush       (flush),
        .halted      (halted),
        .wbErr       (wbErr),
        .stallCycles (stallCycles)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = empty, 1 = holding, 2 = halted.
    int          m_mode;
    logic [31:0] m_instr;
    bit          m_pend [16];
    bit          m_err;
    int          m_stall;
    bit          m_fire;
    bit          m_hazard;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_writes(input logic [3:0] op);
        return !(op == 4'h0 || op == 4'hA || op == 4'hB || op == 4'hF);
    endfunction

    function automatic bit still_pending(input int r);
        return m_pend[r] && !(wbValid && (int'(wbRd) == r));
    endfunction

    function automatic logic [15:0] model_pend_vec();
        logic [15:0] v = '0;
        for (int r = 0; r < 16; r++) v[r] = m_pend[r];
        return v;
    endfunction

    // Apply inputs just after a posedge, then compare everything at negedge.
    task automatic drive(input bit iv, input logic [31:0] ins, input bit ir,
                         input bit wbv, input logic [3:0] wbr, input bit fl);
        logic [3:0]  op, rd, rs1, rs2;
        logic [31:0] imm;
        bit          wr;
        instrValid = iv; instrIn = ins; issueReady = ir;
        wbValid = wbv; wbRd = wbr; flush = fl;
        #4;
        op  = m_instr[31:28];
        rd  = m_instr[27:24];
        rs1 = m_instr[23:20];
        rs2 = m_instr[19:16];
        imm = m_instr[15] ? (32'hFFFF0000 | m_instr[15:0]) : {16'h0, m_instr[15:0]};
        wr  = model_writes(op);
        m_hazard = still_pending(rs1) || still_pending(rs2) || (still_pending(rd) && wr);
        m_fire   = (m_mode == 1) && !m_hazard && ir;
        chk("issueValid",  issueValid,  (m_mode == 1) && !m_hazard);
        chk("instrReady",  instrReady,  (m_mode == 0) || (m_fire && op != 4'hF));
        chk("halted",      halted,      m_mode == 2);
        chk("RAddress1",   RAddress1,   rs1);
        chk("RAddress2",   RAddress2,   rs2);
        chk("issueOpcode", issueOpcode, op);
        chk("issueRd",     issueRd,     rd);
        chk("issueImm",    issueImm,    imm);
        chk("issueWrites", issueWrites, wr);
        chk("wbErr",       wbErr,       m_err);
        chk("stallCycles", stallCycles, m_stall);
        chk("pending",     dut.u_sb.r_pending, model_pend_vec());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_mode = 0; m_instr = '0; m_err = 0; m_stall = 0;
            for (int r = 0; r < 16; r++) m_pend[r] = 0;
        end else begin
            if (m_mode == 1 && m_hazard && m_stall < 65535) m_stall++;
            if (wbValid) begin
                if (!m_pend[wbRd]) m_err = 1;
                m_pend[wbRd] = 0;
            end
            if (m_fire && !flush && model_writes(m_instr[31:28])) m_pend[m_instr[27:24]] = 1;
            if (flush && m_mode != 2) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (instrValid) begin m_mode = 1; m_instr = instrIn; end
            end else if (m_mode == 1 && m_fire) begin
                if (m_instr[31:28] == 4'hF) m_mode = 2;
                else if (instrValid) m_instr = instrIn;
                else m_mode = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin drive(0, 0, 1, 0, 0, 0); tick(); end
    endtask

    task automatic wb(input logic [3:0] r);
        drive(0, 0, 1, 1, r, 0); tick();
    endtask

    initial begin
        logic [31:0] b2b [4];
        b2b[0] = 32'h3812_0005;
        b2b[1] = 32'h4912_FFFF;
        b2b[2] = 32'hA012_8000;
        b2b[3] = 32'hB012_0010;
        m_fire = 0; m_hazard = 0;
        rst_n = 1'b0;
        instrValid = 0; instrIn = 0; issueReady = 0; wbValid = 0; wbRd = 0; flush = 0;
        @(posedge clk); #1;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        drive(0, 0, 1, 0, 0, 0);
        chk("rst_issueValid", issueValid, 0);
        chk("rst_instrReady", instrReady, 1);
        chk("rst_stall", stallCycles, 0);
        chk("rst_opcode", issueOpcode, 0);
        tick();

        // 1: ADD r3 <- r1, r2
        drive(1, 32'h1312_0000, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("t1_valid", issueValid, 1);
        chk("t1_ra1", RAddress1, 1);
        chk("t1_ra2", RAddress2, 2);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("t1_pend3", dut.u_sb.r_pending, 16'h0008);
        tick();

        // 2: SUB r4 <- r3, r1 stalls until r3 retires
        drive(1, 32'h2431_0000, 1, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk("t2_stall_valid", issueValid, 0);
            tick();
        end
        drive(0, 0, 1, 1, 4'd3, 0);
        chk("t2_stall_count", stallCycles, 3);
        chk("t2_bypass_valid", issueValid, 1);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("t2_pend4", dut.u_sb.r_pending, 16'h0010);
        tick();
        wb(4'd4);

        // 3: back-to-back independent instructions
        drive(1, b2b[0], 1, 0, 0, 0); tick();
        for (int k = 1; k < 4; k++) begin
            drive(1, b2b[k], 1, 0, 0, 0);
            chk("t3_ready", instrReady, 1);
            chk("t3_valid", issueValid, 1);
            if (k == 2) chk("t3_imm_neg", issueImm, 32'hFFFF_FFFF);
            tick();
        end
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("t3_pend", dut.u_sb.r_pending, 16'h0300);
        tick();
        wb(4'd8); wb(4'd9);

        // 4: new r5 writer issues in the same cycle the older r5 retires
        drive(1, 32'h1512_0000, 1, 0, 0, 0); tick();
        drive(1, 32'h6567_0000, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 4'd5, 0);
        chk("t4_valid", issueValid, 1);
        tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("t4_pend5", dut.u_sb.r_pending, 16'h0020);
        tick();
        wb(4'd5);

        // 5: flush a stalled instruction; stray writeback flags wbErr
        drive(1, 32'h1234_0000, 1, 0, 0, 0); tick();
        drive(1, 32'h2120_0000, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(1, 32'h1612_0000, 1, 0, 0, 1); tick();
        drive(0, 0, 1, 0, 0, 0);
        chk("t5_valid", issueValid, 0);
        chk("t5_ready", instrReady, 1);
        chk("t5_pend", dut.u_sb.r_pending, 16'h0004);
        tick();
        wb(4'd7);
        drive(0, 0, 1, 0, 0, 0);
        chk("t5_wberr", wbErr, 1);
        tick();

        // 6: HALT freezes the stage until reset
        drive(1, 32'hF000_0000, 1, 0, 0, 0); tick();
        drive(1, 32'h1812_0000, 1, 0, 0, 0);
        chk("t6_halt_valid", issueValid, 1);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1, 32'h1812_0000, 1, (k == 2), 4'd2, (k == 3));
            chk("t6_halted", halted, 1);
            chk("t6_ready", instrReady, 0);
            tick();
        end
        drive(0, 0, 1, 0, 0, 0);
        chk("t6_pend_cleared", dut.u_sb.r_pending, 16'h0000);
        tick();
        rst_n = 1'b0;
        drive(0, 0, 1, 0, 0, 0); tick();
        rst_n = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        chk("t6_rst_halted", halted, 0);
        chk("t6_rst_ready", instrReady, 1);
        chk("t6_rst_wberr", wbErr, 0);
        tick();
        wb(4'd2);
        drive(0, 0, 1, 0, 0, 0);
        chk("t6_post_rst_wberr", wbErr, 1);
        tick();
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
